seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Iterative restoring divider for the calculator datapath; inverse of the 4x4
//  Wallace multiplier (2W-bit product / W-bit factor -> factor). One quotient
//  bit per clock, start/done handshake toward the calculator control FSM.
// PARAMETERS
//  WIDTH  4  divisor/remainder width; dividend and quotient are 2*WIDTH bits
// PORTS
//  clk        in   1        system clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  start      in   1        request; sampled only in IDLE or DONE
//  dividend   in   2*WIDTH  numerator, captured on accepted start
//  divisor    in   WIDTH    denominator, captured on accepted start
//  busy       out  1        high while in RUN
//  done       out  1        one-cycle pulse, result valid
//  quotient   out  2*WIDTH  result, held until next accepted start
//  remainder  out  WIDTH    result, held until next accepted start
//  div_zero   out  1        divisor was 0 for the held result
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; busy, done, div_zero=0; quotient,
//    remainder and all internal regs=0. Reset mid-RUN aborts, no done pulse.
//  - FSM: IDLE -start-> RUN (divisor!=0) or DONE (divisor==0);
//    RUN -count==0-> DONE; DONE -> IDLE, or -> RUN/DONE if start high (
//    back-to-back accept). start in RUN ignored; inputs may change freely.
//  - Accept edge: latch dividend into shift reg Q, divisor into D, partial
//    remainder R (WIDTH+1 bits)=0, count=2*WIDTH, clear div_zero.
//  - Each RUN edge: R'={R[W-1:0],Q[MSB]}; Q<<=1; if R'>=D then R=R'-D, Q[0]=1
//    else R=R', Q[0]=0; count--. Unsigned, no overflow (quotient is 2*WIDTH).
//  - Latency: done high in the cycle after the 2*WIDTH-th RUN edge, i.e.
//    2*WIDTH cycles after the accept edge (8 for WIDTH=4); quotient/remainder
//    update on the same edge done rises; busy falls on that edge.
//  - Divide by zero: no iterations; done pulses the cycle after accept;
//    quotient=all ones, remainder=0, div_zero=1.
//  - Dividend 0: normal run, quotient=0, remainder=0.
//  - Outputs quotient/remainder/div_zero stable between done and next accept;
//    they are not cleared while busy (hold prior result until overwritten).
// CONFIGURATION
//  DIV_SIGNED_EN defined: operands two's complement. Magnitudes are divided
//  by the unsigned core; quotient negated if operand signs differ, remainder
//  takes sign of dividend (truncate toward zero). One extra fix-up cycle:
//  latency 2*WIDTH+1. Div-by-zero result unchanged (all ones, 0, flag).
//  Undefined: pure unsigned as above, latency 2*WIDTH.
// TESTING (WIDTH=4, unsigned unless noted)
//  1 143/11 (0x8F/0xB) -> after 8 clks done=1, quotient=13, remainder=0
//  2 200/7 -> quotient=28, remainder=4; 225/15 -> quotient=15, remainder=0
//  3 divisor=0, dividend=99 -> done next cycle, quotient=0xFF, rem=0,
//    div_zero=1, busy never high
//  4 start pulsed mid-run with new operands -> ignored, first result intact;
//    start held high in DONE cycle -> second division accepted back-to-back
//  5 rst_n low 3 clks into a run -> all outputs 0 immediately, no done
//    pulse; next start completes normally
//  6 DIV_SIGNED_EN: -100/7 -> quotient=-14 (0xF2), remainder=-2 (0xE),
//    done after 9 clks

Source files
------------

// File: rtl/seq_divider.sv
// Iterative restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (adds one sign fix-up cycle).
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_zero
);
    localparam int QW = 2 * WIDTH;
    localparam int CW = $clog2(QW + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state;
    logic [QW-1:0]      q_reg;
    logic [WIDTH-1:0]   d_reg;
    logic [WIDTH-1:0]   r_reg;
    logic [CW-1:0]      count;

    logic [WIDTH:0]     r_shift;
    logic               r_ge;
    logic [WIDTH-1:0]   r_sub;
    logic [WIDTH-1:0]   r_next;
    logic [QW-1:0]      q_next;
    logic [QW-1:0]      q_load;
    logic [WIDTH-1:0]   d_load;

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    function automatic logic [QW-1:0] cneg_q(input logic [QW-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] cneg_r(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // The core always sees magnitudes; signs are reapplied in FIX.
    assign q_load = cneg_q(dividend, dividend[QW-1]);
    assign d_load = cneg_r(divisor, divisor[WIDTH-1]);
`else
    assign q_load = dividend;
    assign d_load = divisor;
`endif

    // R stays below D between steps, so the subtraction fits in WIDTH bits.
    always_comb begin
        r_shift = {r_reg, q_reg[QW-1]};
        r_ge    = (r_shift >= {1'b0, d_reg});
        r_sub   = r_shift[WIDTH-1:0] - d_reg;
        r_next  = r_ge ? r_sub : r_shift[WIDTH-1:0];
        q_next  = {q_reg[QW-2:0], r_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            q_reg     <= '0;
            d_reg     <= '0;
            r_reg     <= '0;
            count     <= '0;
`ifdef DIV_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        q_reg    <= q_load;
                        d_reg    <= d_load;
                        r_reg    <= '0;
                        count    <= CW'(QW);
                        div_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
                        neg_q    <= dividend[QW-1] ^ divisor[WIDTH-1];
                        neg_r    <= dividend[QW-1];
`endif
                        if (divisor == '0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            quotient  <= '1;
                            remainder <= '0;
                            div_zero  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        busy <= 1'b0;
`ifdef DIV_SIGNED_EN
                        state <= FIX;
`else
                        state     <= DONE;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next;
`endif
                    end
                end
`ifdef DIV_SIGNED_EN
                FIX: begin
                    state     <= DONE;
                    done      <= 1'b1;
                    quotient  <= cneg_q(q_reg, neg_q);
                    remainder <= cneg_r(r_reg, neg_r);
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=4); follows DIV_SIGNED_EN for vectors and latency.
module tb_seq_divider;
`ifdef DIV_SIGNED_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [3:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts clock edges after the accept edge until done is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        int seen;

`ifdef DIV_SIGNED_EN
        vecs.push_back('{8'h9C, 4'h7, 8'hF2, 4'hE, 1'b0});  // -100 / 7
        vecs.push_back('{8'h64, 4'h9, 8'hF2, 4'h2, 1'b0});  // 100 / -7
        vecs.push_back('{8'h9C, 4'h9, 8'h0E, 4'hE, 1'b0});  // -100 / -7
        vecs.push_back('{8'h7F, 4'h8, 8'hF1, 4'h7, 1'b0});  // 127 / -8
        vecs.push_back('{8'h07, 4'h0, 8'hFF, 4'h0, 1'b1});
        vecs.push_back('{8'h00, 4'h5, 8'h00, 4'h0, 1'b0});
`else
        vecs.push_back('{8'd143, 4'd11, 8'd13,  4'd0, 1'b0});
        vecs.push_back('{8'd200, 4'd7,  8'd28,  4'd4, 1'b0});
        vecs.push_back('{8'd225, 4'd15, 8'd15,  4'd0, 1'b0});
        vecs.push_back('{8'd99,  4'd0,  8'hFF,  4'd0, 1'b1});
        vecs.push_back('{8'd0,   4'd5,  8'd0,   4'd0, 1'b0});
        vecs.push_back('{8'd255, 4'd1,  8'd255, 4'd0, 1'b0});
        vecs.push_back('{8'd5,   4'd9,  8'd0,   4'd5, 1'b0});
        vecs.push_back('{8'd17,  4'd15, 8'd1,   4'd2, 1'b0});
`endif

        rst_n = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_div_zero", div_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].dz ? 0 : 1);
            wait_done(n);
            chk($sformatf("v%0d_latency", i), n, vecs[i].dz ? 0 : LAT);
            chk($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
            chk($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
            chk($sformatf("v%0d_div_zero", i), div_zero, vecs[i].dz);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), done, 0);
        end

        // start pulsed mid-run must be ignored
        issue(8'd100, 4'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        dividend = 8'd50;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        chk("midrun_latency", n + 4, LAT);
        chk("midrun_quotient", quotient, 14);
        chk("midrun_remainder", remainder, 2);

        // start held during the DONE cycle: accepted back-to-back
        dividend = 8'd60;
        divisor  = 4'd4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_hold_quotient", quotient, 14);
        wait_done(n);
        chk("b2b_latency", n, LAT);
        chk("b2b_quotient", quotient, 15);
        chk("b2b_remainder", remainder, 0);

        // reset mid-run aborts without a done pulse
        issue(8'd100, 4'd7);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            seen = seen | int'(done);
        end
        chk("abort_no_done", seen, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'd50, 4'd3);
        wait_done(n);
        chk("after_abort_latency", n, LAT);
        chk("after_abort_quotient", quotient, 16);
        chk("after_abort_remainder", remainder, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
